// File: rtl/pixel_array_readout_pkg.sv
// Shared types and defaults for the pixel array readout block.
// Holds the FSM state encoding and the default array geometry.
package pixel_readout_pkg;

   localparam int DEF_BIT_DEPTH = 10;
   localparam int DEF_N_ROWS    = 2;
   localparam int DEF_N_COLS    = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_CAPTURE,
      ST_OUTPUT,
      ST_DONE
   } state_t;

   // Counter width for n items, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_array_readout_if.sv
// Pixel stream handshake between the readout block and its consumer.
// The master drives data/valid/last, the slave answers with ready.
interface pixel_array_readout_if
   import pixel_readout_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH
);

   logic [BIT_DEPTH-1:0] PIXEL_DATA;
   logic                 PIXEL_VALID;
   logic                 PIXEL_READY;
   logic                 PIXEL_LAST;

   modport master (
      output PIXEL_DATA,
      output PIXEL_VALID,
      output PIXEL_LAST,
      input  PIXEL_READY
   );

   modport slave (
      input  PIXEL_DATA,
      input  PIXEL_VALID,
      input  PIXEL_LAST,
      output PIXEL_READY
   );

endinterface

// File: rtl/pixel_array_readout_gray_to_binary.sv
// Combinational Gray-to-binary decoder for one pixel counter code.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary
   import pixel_readout_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH
) (
   input  logic [BIT_DEPTH-1:0] gray,
   output logic [BIT_DEPTH-1:0] binary
);

   logic acc;

   always_comb begin
      binary = '0;
      acc    = 1'b0;
      for (int i = BIT_DEPTH - 1; i >= 0; i--) begin
         acc       = acc ^ gray[i];
         binary[i] = acc;
      end
   end

endmodule

// File: rtl/pixel_array_readout.sv
// Frame readout of a Gray-counter pixel array: selects each row,
// captures and decodes it, then streams the pixels over a handshake.
module pixel_array_readout
   import pixel_readout_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH,
   parameter int N_ROWS    = DEF_N_ROWS,
   parameter int N_COLS    = DEF_N_COLS
) (
   input  logic                        READOUT_CLOCK,
   input  logic                        READOUT_RESET,
   input  logic                        READ_START,
   output logic [N_ROWS-1:0]           ROW_SELECT,
   input  logic [N_COLS*BIT_DEPTH-1:0] COLUMN_DATA,
   output logic                        BUSY,
   output logic                        FRAME_DONE,
   pixel_array_readout_if.master       pixel
);

   localparam int RW = cnt_width(N_ROWS);
   localparam int CW = cnt_width(N_COLS);

   localparam logic [RW-1:0] ROW_MAX = RW'(N_ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(N_COLS - 1);

   state_t               state;
   logic [RW-1:0]        row;
   logic [CW-1:0]        col;
   logic [N_ROWS-1:0]    sel;
   logic                 valid;
   logic                 last;
   logic                 busy;
   logic                 done;
   logic [BIT_DEPTH-1:0] buffer  [N_COLS];
   logic [BIT_DEPTH-1:0] decoded [N_COLS];
   logic                 row_last;
   logic                 next_is_last_col;

   for (genvar c = 0; c < N_COLS; c++) begin : g_dec
      gray_to_binary #(
         .BIT_DEPTH (BIT_DEPTH)
      ) u_dec (
         .gray   (COLUMN_DATA[c*BIT_DEPTH +: BIT_DEPTH]),
         .binary (decoded[c])
      );
   end

   assign row_last         = (row == ROW_MAX);
   assign next_is_last_col = (int'(col) + 2 == N_COLS);

   always_ff @(posedge READOUT_CLOCK) begin
      if (READOUT_RESET) begin
         state <= ST_IDLE;
         row   <= '0;
         col   <= '0;
         sel   <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int c = 0; c < N_COLS; c++) begin
            buffer[c] <= '0;
         end
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (READ_START) begin
                  state <= ST_SELECT;
                  row   <= '0;
                  col   <= '0;
                  sel   <= N_ROWS'(1);
                  busy  <= 1'b1;
               end
            end
            ST_SELECT: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               state  <= ST_OUTPUT;
               sel    <= '0;
               valid  <= 1'b1;
               last   <= row_last && (N_COLS == 1);
               buffer <= decoded;
            end
            ST_OUTPUT: begin
               // Data and last hold until the consumer takes the pixel.
               if (pixel.PIXEL_READY) begin
                  if (col == COL_MAX) begin
                     col   <= '0;
                     valid <= 1'b0;
                     last  <= 1'b0;
                     if (row_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= ST_SELECT;
                        row   <= row + 1'b1;
                        sel   <= N_ROWS'(1) << (row + 1'b1);
                     end
                  end else begin
                     col  <= col + 1'b1;
                     last <= row_last && next_is_last_col;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               sel   <= '0;
               valid <= 1'b0;
               last  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ROW_SELECT  = sel;
   assign BUSY        = busy;
   assign FRAME_DONE  = done;

   assign pixel.PIXEL_VALID = valid;
   assign pixel.PIXEL_LAST  = last;
   assign pixel.PIXEL_DATA  = valid ? buffer[col] : '0;

endmodule

// File: tb/tb_pixel_array_readout.sv
// Bench for pixel_array_readout: a 2x2 Gray-counter array model feeds
// the column bus and an expected-pixel queue is checked every cycle.
module tb_pixel_array_readout;
   import pixel_readout_pkg::*;

   localparam int BD = 10;
   localparam int NR = 2;
   localparam int NC = 2;

   typedef struct {
      logic [BD-1:0] data;
      logic          last;
   } px_t;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             start = 1'b0;
   logic [NR-1:0]    rs;
   logic [NC*BD-1:0] col_data;
   logic             busy;
   logic             fdone;
   logic [NC*BD-1:0] gmem [NR];

   px_t exp_q [$];
   int  checks   = 0;
   int  failures = 0;
   int  done_cnt = 0;
   int  exp_done = 0;

   pixel_array_readout_if #(.BIT_DEPTH(BD)) pix ();

   pixel_array_readout #(
      .BIT_DEPTH (BD),
      .N_ROWS    (NR),
      .N_COLS    (NC)
   ) dut (
      .READOUT_CLOCK (clk),
      .READOUT_RESET (rst),
      .READ_START    (start),
      .ROW_SELECT    (rs),
      .COLUMN_DATA   (col_data),
      .BUSY          (busy),
      .FRAME_DONE    (fdone),
      .pixel         (pix)
   );

   always #5 clk = ~clk;

   // Array model: the selected row drives its Gray codes onto the bus.
   always_comb begin
      col_data = '1;
      if (rs == 2'b01) col_data = gmem[0];
      else if (rs == 2'b10) col_data = gmem[1];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [BD-1:0] gray(input logic [BD-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic load_raw(input logic [BD-1:0] g0, g1, g2, g3,
                           input logic [BD-1:0] e0, e1, e2, e3);
      gmem[0] = {g1, g0};
      gmem[1] = {g3, g2};
      exp_q.push_back('{e0, 1'b0});
      exp_q.push_back('{e1, 1'b0});
      exp_q.push_back('{e2, 1'b0});
      exp_q.push_back('{e3, 1'b1});
   endtask

   task automatic load_bin(input logic [BD-1:0] b0, b1, b2, b3);
      load_raw(gray(b0), gray(b1), gray(b2), gray(b3), b0, b1, b2, b3);
   endtask

   logic          pv = 1'b0;
   logic          pr = 1'b0;
   logic          pl = 1'b0;
   logic [BD-1:0] pd = '0;
   px_t           e;

   always @(negedge clk) begin
      chk("rowsel_legal",
          32'($onehot0(rs) && !(pix.PIXEL_VALID && rs != '0)), 32'd1);
      if (fdone) done_cnt <= done_cnt + 1;
      if (pix.PIXEL_VALID && pv && !pr) begin
         chk("hold_data", 32'(pix.PIXEL_DATA), 32'(pd));
         chk("hold_last", 32'(pix.PIXEL_LAST), 32'(pl));
      end
      if (pix.PIXEL_VALID && pix.PIXEL_READY) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 32'(pix.PIXEL_DATA), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("pixel_data", 32'(pix.PIXEL_DATA), 32'(e.data));
            chk("pixel_last", 32'(pix.PIXEL_LAST), 32'(e.last));
         end
      end
      pv <= pix.PIXEL_VALID;
      pr <= pix.PIXEL_READY;
      pd <= pix.PIXEL_DATA;
      pl <= pix.PIXEL_LAST;
   end

   function automatic logic [5:0] obs();
      return {rs, pix.PIXEL_VALID, pix.PIXEL_LAST, fdone, busy};
   endfunction

   // mode 0: clean frame, 1: stray start in row 0, 2: reset in row-1 capture
   task automatic trace(input int mode);
      logic [5:0] tbl [10];
      tbl = '{6'b010001, 6'b010001, 6'b001001, 6'b001001, 6'b100001,
              6'b100001, 6'b001001, 6'b001101, 6'b000011, 6'b000000};
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mode == 2 && k == 7) begin
            chk("reset_outputs", 32'(obs()), 32'd0);
            chk("reset_data", 32'(pix.PIXEL_DATA), 32'd0);
            #1 rst = 1'b0;
            exp_q.delete();
            return;
         end
         chk($sformatf("trace_m%0d_k%0d", mode, k), 32'(obs()),
             32'(tbl[k-1]));
         if (mode == 1 && k == 3) #1 start = 1'b1;
         if (mode == 1 && k == 4) #1 start = 1'b0;
         if (mode == 2 && k == 6) #1 rst = 1'b1;
      end
      exp_done++;
      if (mode == 1) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_start_not_queued", 32'(busy), 32'd0);
         end
      end
   endtask

   task automatic backpressure();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k >= 4 && k <= 9) begin
            chk("bp_valid", 32'(pix.PIXEL_VALID), 32'd1);
            chk("bp_data", 32'(pix.PIXEL_DATA), 32'h1A5);
         end
         if (k == 10) chk("bp_row1_select", 32'(rs), 32'b10);
         if (k == 13) chk("bp_last", 32'(pix.PIXEL_LAST), 32'd1);
         if (k == 14) chk("bp_done", 32'(fdone), 32'd1);
         if (k == 15) chk("bp_idle", 32'(busy), 32'd0);
         if (k == 4) #1 pix.PIXEL_READY = 1'b0;
         if (k == 9) #1 pix.PIXEL_READY = 1'b1;
      end
      exp_done++;
   endtask

   task automatic run_frame();
      int n;
      n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (!fdone && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_in_time", 32'(fdone), 32'd1);
      if (fdone) exp_done++;
   endtask

   initial begin
      pix.PIXEL_READY = 1'b1;
      gmem[0] = '0;
      gmem[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(obs()), 32'd0);
      chk("reset_pixel_data", 32'(pix.PIXEL_DATA), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      load_raw(10'h000, 10'h007, 10'h200, 10'h3FF,
               10'h000, 10'h005, 10'h3FF, 10'h2AA);
      trace(0);
      chk("done_count_decode", 32'(done_cnt), 32'(exp_done));

      load_bin(10'h0F0, 10'h1A5, 10'h2C3, 10'h3FE);
      backpressure();
      chk("done_count_bp", 32'(done_cnt), 32'(exp_done));

      load_bin(10'h111, 10'h222, 10'h333, 10'h044);
      trace(1);
      chk("done_count_stray", 32'(done_cnt), 32'(exp_done));

      load_bin(10'h3C0, 10'h03C, 10'h155, 10'h2AB);
      trace(2);
      chk("done_count_abort", 32'(done_cnt), 32'(exp_done));
      load_bin(10'h001, 10'h010, 10'h100, 10'h3FF);
      trace(0);
      chk("done_count_restart", 32'(done_cnt), 32'(exp_done));

      for (int k = 0; k < 1024; k += 4) begin
         load_bin(BD'(k), BD'(k + 1), BD'(k + 2), BD'(k + 3));
         run_frame();
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("done_count_final", 32'(done_cnt), 32'(exp_done));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
